regfile_dbg_ctrl: RTL and testbench

- Debug-port controller and arbiter for the CPU register file (Z/X/Y/A, plus S when compiled in).
- Takes byte-wide read/write requests from an external debug/monitor master and waits for an instruction boundary.
- Stalls the core, takes over the register-file read and write ports for one access, returns data, then releases the core or keeps it halted.
- Sits between the core's register-file control outputs and the register file.

---
 rtl/regfile_dbg_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_regfile_dbg_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dbg_ctrl.sv
// Debug-port controller and arbiter for the CPU register file.
// A debug master requests one byte-wide register read or write. The
// controller waits for an instruction boundary, stalls the core, takes the
// register-file ports for a single cycle, then releases the core or keeps it
// halted for further accesses.
//
// Build option: define DBG_STACK_EN to allow reads of the stack pointer (S)
// through dbg_sel=4. Without it, any access to sel 4 reports an error.

module regfile_dbg_ctrl #(
    parameter int SYNC_TIMEOUT = 255,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       core_sync,
    output logic       core_rdy,

    input  logic       core_reg_we,
    input  logic [1:0] core_reg_src,
    input  logic [1:0] core_reg_dst,
    input  logic [7:0] core_dst,

    output logic       rf_reg_we,
    output logic [1:0] rf_reg_src,
    output logic [1:0] rf_reg_dst,
    output logic [7:0] rf_dst,
    input  logic [7:0] rf_src,

    input  logic [7:0] S,

    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [2:0] dbg_sel,
    input  logic [7:0] dbg_wdata,
    input  logic       dbg_halt,
    output logic       dbg_ack,
    output logic [7:0] dbg_rdata,
    output logic       dbg_err
);

    // state      | meaning
    // -----------+------------------------------------------------------
    // IDLE       | no access in flight; core runs or sits halted
    // WAIT_SYNC  | core running, waiting for an opcode fetch (bounded)
    // DRAIN      | core stalled, its last writeback still passes through
    // ACCESS     | debug side owns the register-file ports for one cycle
    // ACK        | completion pulse; decide release or stay halted
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SYNC,
        ST_DRAIN,
        ST_ACCESS,
        ST_ACK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             core_rdy_q, core_rdy_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             acc_core;
    logic             acc_wr;
    logic             acc_rd_core;
    logic             acc_rd_stack;

    // Register selects 0..3 map onto the register file; 4 is S; 5..7 are reserved.
    assign acc_core    = ~dbg_sel[2];
    assign acc_wr      = dbg_we & acc_core;
    assign acc_rd_core = ~dbg_we & acc_core;

`ifdef DBG_STACK_EN
    assign acc_rd_stack = ~dbg_we & (dbg_sel == 3'd4);
`else
    logic unused_s;
    assign acc_rd_stack = 1'b0;
    assign unused_s     = ^S;
`endif

    assign core_rdy  = core_rdy_q;
    assign dbg_ack   = (state_q == ST_ACK);
    assign dbg_rdata = rdata_q;
    assign dbg_err   = err_q;

    // State and datapath registers; reset aborts any access without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            core_rdy_q <= 1'b1;
            rdata_q    <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            core_rdy_q <= core_rdy_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic, sync timeout and access result capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        core_rdy_d = core_rdy_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (dbg_req) begin
                    err_d = 1'b0;
                    if (core_rdy_q) begin
                        state_d = ST_WAIT_SYNC;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end else if (!core_rdy_q && !dbg_halt) begin
                    core_rdy_d = 1'b1;
                end
            end

            ST_WAIT_SYNC: begin
                // A sync arriving on the last allowed cycle still wins.
                if (core_sync) begin
                    state_d    = ST_DRAIN;
                    core_rdy_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ACK;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DRAIN: begin
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                state_d = ST_ACK;
                if (acc_rd_core) begin
                    rdata_d = rf_src;
                end else if (acc_rd_stack) begin
                    rdata_d = S;
                end else if (!acc_wr) begin
                    err_d = 1'b1;
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
                if (!dbg_halt) begin
                    core_rdy_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register-file port mux: core pass-through except during the access cycle.
    always_comb begin
        rf_reg_we  = core_reg_we;
        rf_reg_src = core_reg_src;
        rf_reg_dst = core_reg_dst;
        rf_dst     = core_dst;
        if (state_q == ST_ACCESS) begin
            rf_reg_we  = acc_wr;
            rf_reg_src = dbg_sel[1:0];
            rf_reg_dst = dbg_sel[1:0];
            rf_dst     = dbg_wdata;
        end
    end

endmodule

// File: tb/tb_regfile_dbg_ctrl.sv
// Testbench for regfile_dbg_ctrl: behavioural register file and core driver,
// reference model of the debug protocol, and an ack-driven scoreboard.

module tb_regfile_dbg_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       core_sync;
    logic       core_rdy;
    logic       core_reg_we;
    logic [1:0] core_reg_src;
    logic [1:0] core_reg_dst;
    logic [7:0] core_dst;
    logic       rf_reg_we;
    logic [1:0] rf_reg_src;
    logic [1:0] rf_reg_dst;
    logic [7:0] rf_dst;
    logic [7:0] rf_src;
    logic [7:0] S;
    logic       dbg_req;
    logic       dbg_we;
    logic [2:0] dbg_sel;
    logic [7:0] dbg_wdata;
    logic       dbg_halt;
    logic       dbg_ack;
    logic [7:0] dbg_rdata;
    logic       dbg_err;

    regfile_dbg_ctrl #(.SYNC_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .core_sync(core_sync), .core_rdy(core_rdy),
        .core_reg_we(core_reg_we), .core_reg_src(core_reg_src),
        .core_reg_dst(core_reg_dst), .core_dst(core_dst),
        .rf_reg_we(rf_reg_we), .rf_reg_src(rf_reg_src),
        .rf_reg_dst(rf_reg_dst), .rf_dst(rf_dst), .rf_src(rf_src),
        .S(S),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_sel(dbg_sel),
        .dbg_wdata(dbg_wdata), .dbg_halt(dbg_halt), .dbg_ack(dbg_ack),
        .dbg_rdata(dbg_rdata), .dbg_err(dbg_err)
    );

    always #5 clk = ~clk;

    // Behavioural register file (Z/X/Y/A) driven by the controller's rf_* ports.
    logic [7:0] rf_mem [4];
    assign rf_src = rf_mem[rf_reg_src];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= 8'h00;
        end else if (rf_reg_we) begin
            rf_mem[rf_reg_dst] <= rf_dst;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
        logic       rdy;
        int         start;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_regs [4];
    logic [7:0] ref_rdata;
    bit         ref_halted;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
        ref_rdata  = 8'h00;
        ref_halted = 1'b0;
        sb_q.delete();
    endtask

    // Monitor: every ack is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && dbg_ack) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("ack_rdata", dbg_rdata, mon_e.rdata);
                check("ack_err", dbg_err, mon_e.err);
                check("ack_latency", cyc - mon_e.start, mon_e.lat);
                check("ack_core_rdy", core_rdy, mon_e.rdy);
            end
        end
    end

    // One debug access. d = WAIT_SYNC cycles without sync before core_sync rises.
    // drain_wr makes the core write Y (value dw) during the DRAIN cycle.
    task automatic do_req(input bit we, input logic [2:0] sel, input logic [7:0] wd,
                          input bit halt, input int d, input logic [7:0] sval,
                          input bit drain_wr, input logic [7:0] dw);
        exp_t e;
        bit   was_halted, timeout, legal, done;
        int   j, low;
        was_halted = ref_halted;
        timeout    = !was_halted && (d >= TO);
`ifdef DBG_STACK_EN
        legal = (sel < 3'd4) || (sel == 3'd4 && !we);
`else
        legal = (sel < 3'd4);
`endif
        e.rdata = ref_rdata;
        e.err   = 1'b0;
        if (timeout) begin
            e.err = 1'b1;
            e.lat = TO + 1;
            e.rdy = 1'b1;
        end else begin
            if (drain_wr && !was_halted) ref_regs[2] = dw;
            e.lat = was_halted ? 2 : 4 + d;
            e.rdy = 1'b0;
            if (!legal) e.err = 1'b1;
            else if (we) ref_regs[sel[1:0]] = wd;
            else e.rdata = (sel == 3'd4) ? sval : ref_regs[sel[1:0]];
            ref_halted = halt;
        end
        ref_rdata = e.rdata;

        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = we; dbg_sel = sel; dbg_wdata = wd;
        dbg_halt = halt; S = sval; core_sync = 1'b0; core_reg_we = 1'b0;
        e.start = cyc;
        sb_q.push_back(e);
        j = 0; low = 0; done = 1'b0;
        while (!done && j < 60) begin
            if (!core_rdy) low++;
            core_sync    = (j >= 1 + d);
            core_reg_we  = drain_wr && (j == 2 + d);
            core_reg_dst = 2'd2;
            core_dst     = dw;
            @(negedge clk);
            if (dbg_ack) begin
                done    = 1'b1;
                dbg_req = 1'b0;
            end
            @(posedge clk); #1;
            j++;
        end
        core_sync   = 1'b0;
        core_reg_we = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ack_wait actual=no_ack required=ack (cycle %0d)", cyc);
            dbg_req = 1'b0;
            sb_q.delete();
        end
        check("rdy_low_cycles", low, timeout ? 0 : 3);
        check("rdy_after_ack", core_rdy, !ref_halted);
    endtask

    // Idle cycles with random core traffic through the pass-through path.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            core_reg_src = 2'($urandom);
            core_reg_dst = 2'($urandom);
            core_dst     = 8'($urandom);
            core_reg_we  = !ref_halted && ($urandom_range(0, 1) == 1);
            if (core_reg_we) ref_regs[core_reg_dst] = core_dst;
            #1;
            check("pass_through", {rf_reg_we, rf_reg_src, rf_reg_dst, rf_dst},
                  {core_reg_we, core_reg_src, core_reg_dst, core_dst});
        end
        @(posedge clk); #1;
        core_reg_we = 1'b0;
    endtask

    initial begin
        logic [2:0] sel;
        rst = 1'b1; core_sync = 1'b0; core_reg_we = 1'b0; core_reg_src = 2'd0;
        core_reg_dst = 2'd0; core_dst = 8'h00; S = 8'h00; dbg_req = 1'b0;
        dbg_we = 1'b0; dbg_sel = 3'd0; dbg_wdata = 8'h00; dbg_halt = 1'b0;
        ref_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_core_rdy", core_rdy, 1);
        check("reset_ack", dbg_ack, 0);
        check("reset_rdata", dbg_rdata, 0);
        check("reset_err", dbg_err, 0);

        // Load A, stay halted, then a halted read of A.
        do_req(1'b1, 3'd3, 8'h41, 1'b1, 2, 8'h00, 1'b0, 8'h00);
        do_req(1'b0, 3'd3, 8'h00, 1'b1, 0, 8'h00, 1'b0, 8'h00);
        // Halted read of Z that releases the core.
        do_req(1'b0, 3'd0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 8'h00);
        // Running core, sync three cycles after req: write X, then read it back.
        do_req(1'b1, 3'd1, 8'h5A, 1'b0, 2, 8'h00, 1'b0, 8'h00);
        do_req(1'b0, 3'd1, 8'h00, 1'b0, 0, 8'h00, 1'b0, 8'h00);
        // Core writes Y in DRAIN while debug writes A; both must survive.
        do_req(1'b1, 3'd3, 8'hC3, 1'b0, 0, 8'h00, 1'b1, 8'h77);
        do_req(1'b0, 3'd2, 8'h00, 1'b0, 1, 8'h00, 1'b0, 8'h00);
        do_req(1'b0, 3'd3, 8'h00, 1'b0, 3, 8'h00, 1'b0, 8'h00);
        // No sync at all: timeout error, core never stalls. Then sync on the last cycle.
        do_req(1'b0, 3'd0, 8'h00, 1'b0, 20, 8'h00, 1'b0, 8'h00);
        do_req(1'b0, 3'd1, 8'h00, 1'b0, TO - 1, 8'h00, 1'b0, 8'h00);
        // Three halted back-to-back reads, then drop dbg_halt.
        do_req(1'b0, 3'd0, 8'h00, 1'b1, 1, 8'h00, 1'b0, 8'h00);
        do_req(1'b0, 3'd1, 8'h00, 1'b1, 0, 8'h00, 1'b0, 8'h00);
        do_req(1'b0, 3'd2, 8'h00, 1'b1, 0, 8'h00, 1'b0, 8'h00);
        dbg_halt = 1'b0;
        ref_halted = 1'b0;
        @(posedge clk); #1;
        check("release_after_halt_drop", core_rdy, 1);
        // Stack and reserved selects.
        do_req(1'b0, 3'd4, 8'h00, 1'b0, 1, 8'hFF, 1'b0, 8'h00);
        do_req(1'b1, 3'd4, 8'h12, 1'b0, 0, 8'hFF, 1'b0, 8'h00);
        do_req(1'b0, 3'd6, 8'h00, 1'b1, 0, 8'h33, 1'b0, 8'h00);
        do_req(1'b1, 3'd7, 8'h99, 1'b0, 0, 8'h33, 1'b0, 8'h00);

        for (int n = 0; n < 60; n++) begin
            sel = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), sel, 8'($urandom), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 10), 8'($urandom), 1'b0, 8'h00);
            gap($urandom_range(0, 3));
        end

        // Reset while waiting for sync: no ack, core running, registers at reset.
        do_req(1'b0, 3'd0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 8'h00);
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_sel = 3'd2; dbg_halt = 1'b1; core_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        dbg_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        ref_reset();
        check("rst_core_rdy_next", core_rdy, 1);
        repeat (10) @(posedge clk);
        #1;
        check("rst_core_rdy", core_rdy, 1);
        check("rst_err", dbg_err, 0);
        check("rst_rdata", dbg_rdata, 0);
        dbg_halt = 1'b0;
        do_req(1'b0, 3'd3, 8'h00, 1'b0, 2, 8'h00, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
